// File: rtl/key_pkg.sv
// Shared key-handling constants and debounce state encoding; also used by the click classifier.
package key_pkg;

  localparam int unsigned CLK_HZ = 24_000_000;

  // 20 ms debounce window and 10 s stuck-key timeout at CLK_HZ.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;
  localparam int unsigned DEF_STUCK_CYCLES    = CLK_HZ * 10;

  typedef enum logic [1:0] {
    S_HIGH      = 2'd0,
    S_WAIT_LOW  = 2'd1,
    S_LOW       = 2'd2,
    S_WAIT_HIGH = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_debounce_if.sv
// Button-side signal bundle: raw pin in, debounced level and edge pulses out.
interface key_debounce_if;

  logic key_in;
  logic key_level;
  logic key_neg;
  logic key_pos;
  logic key_stuck;

  modport master (
    output key_in,
    input  key_level,
    input  key_neg,
    input  key_pos,
    input  key_stuck
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_neg,
    output key_pos,
    output key_stuck
  );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to RstVal.
module key_sync #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Active-low push-button debouncer: synchronise, filter bounce, emit press/release pulses.
// Optional stuck-key detector enabled by defining KEY_DEB_STUCK_DET_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (STUCK_CYCLES < 1) begin : g_bad_stuck
    $error("STUCK_CYCLES must be at least 1");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            key_sync;
  key_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            neg_q;
  logic            pos_q;
  logic            rel_accept;

  key_sync #(
    .RstVal (1'b1)
  ) u_key_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (bus.key_in),
    .q_o   (key_sync)
  );

  assign rel_accept = (state_q == S_WAIT_HIGH) && key_sync && (cnt_q == CntMax);

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HIGH;
      cnt_q   <= '0;
      level_q <= 1'b1;
      neg_q   <= 1'b0;
      pos_q   <= 1'b0;
    end else begin
      neg_q <= 1'b0;
      pos_q <= 1'b0;
      case (state_q)
        S_HIGH: begin
          if (!key_sync) begin
            state_q <= S_WAIT_LOW;
            cnt_q   <= CntW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (key_sync) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= S_LOW;
            level_q <= 1'b0;
            neg_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LOW: begin
          if (key_sync) begin
            state_q <= S_WAIT_HIGH;
            cnt_q   <= CntW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!key_sync) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (rel_accept) begin
            state_q <= S_HIGH;
            level_q <= 1'b1;
            pos_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_HIGH;
          level_q <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.key_level = level_q;
  assign bus.key_neg   = neg_q;
  assign bus.key_pos   = pos_q;

`ifdef KEY_DEB_STUCK_DET_EN
  localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

  logic [StuckW-1:0] stuck_cnt_q;
  logic              stuck_q;
  logic              held;

  assign held = (state_q == S_LOW) || (state_q == S_WAIT_HIGH);

  // Release acceptance wins over counting so the flag drops with key_pos.
  always_ff @(posedge clk) begin
    if (rst || rel_accept) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else if (held && (stuck_cnt_q != StuckMax)) begin
      stuck_cnt_q <= stuck_cnt_q + 1'b1;
      if (stuck_cnt_q == StuckMax - StuckW'(1)) begin
        stuck_q <= 1'b1;
      end
    end
  end

  assign bus.key_stuck = stuck_q;
`else
  assign bus.key_stuck = 1'b0;
`endif

endmodule
